// File: rtl/dma_pkg.sv
// Shared definitions for the DMA AXI engines: AXI encodings, 4 KB boundary, FSM states.
package dma_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam int         BOUNDARY_4K    = 4096;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CALC,
    ST_WAIT_DATA,
    ST_AW,
    ST_W,
    ST_B,
    ST_DONE
  } wr_state_e;

endpackage

// File: rtl/dma_burst_calc.sv
// Burst sizing: the largest INCR burst that fits the remaining beats, the
// maximum burst length and the bytes left before the next 4 KB boundary.
// Only the low 12 address bits matter, so only those are taken in.
module dma_burst_calc
  import dma_pkg::*;
#(
  parameter int DATA_W    = 64,
  parameter int LEN_W     = 16,
  parameter int MAX_BURST = 16,
  localparam int BEATS_W  = $clog2(MAX_BURST) + 1
) (
  input  logic [11:0]        addr_lo,
  input  logic [LEN_W-1:0]   remaining,
  output logic [BEATS_W-1:0] beats
);

  localparam int SIZE = $clog2(DATA_W / 8);

  logic [12:0] bytes_to_4k;
  logic [12:0] beats_to_4k;
  logic [31:0] limit;

  // Minimum of the three limits, evaluated in a wide word so nothing truncates.
  always_comb begin
    bytes_to_4k = 13'(BOUNDARY_4K) - {1'b0, addr_lo};
    beats_to_4k = bytes_to_4k >> SIZE;
    limit       = 32'(MAX_BURST);
    if (32'(beats_to_4k) < limit) limit = 32'(beats_to_4k);
    if (32'(remaining) < limit)   limit = 32'(remaining);
    beats       = BEATS_W'(limit);
  end

endmodule

// File: rtl/dma_axi_wr_engine.sv
// Drains the DMA data FIFO onto AXI4 as INCR write bursts, one burst in flight.
// A burst is only issued once the FIFO holds all of its beats, so W never
// starves; the fall-through FIFO head drives wdata directly.
module dma_axi_wr_engine
  import dma_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 64,
  parameter int LEN_W      = 16,
  parameter int MAX_BURST  = 16,
  parameter int FIFO_DEPTH = 16,
  localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [LEN_W-1:0]    cmd_beats,
  output logic                done,
  output logic                err,
  input  logic [DATA_W-1:0]   fifo_dout,
  input  logic                fifo_empty,
  input  logic [CNT_W-1:0]    fifo_ocup_cnt,
  output logic                fifo_rd_en,
  output logic [ADDR_W-1:0]   awaddr,
  output logic [7:0]          awlen,
  output logic [2:0]          awsize,
  output logic [1:0]          awburst,
  output logic                awvalid,
  input  logic                awready,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wlast,
  output logic                wvalid,
  input  logic                wready,
  input  logic                bvalid,
  input  logic [1:0]          bresp,
  output logic                bready
);

  localparam int SIZE    = $clog2(DATA_W / 8);
  localparam int BEATS_W = $clog2(MAX_BURST) + 1;
  localparam int CMP_W   = CNT_W + 1;

  wr_state_e          state_reg;
  logic [ADDR_W-1:0]  addr_reg;
  logic [LEN_W-1:0]   remaining_reg;
  logic [BEATS_W-1:0] beats_reg;
  logic [BEATS_W-1:0] beat_cnt_reg;
  logic               err_sticky_reg;
  logic               cmd_ready_reg;
  logic               done_reg;
  logic               err_reg;
  logic [ADDR_W-1:0]  awaddr_reg;
  logic [7:0]         awlen_reg;
  logic               awvalid_reg;
  logic               wvalid_reg;
  logic               wlast_reg;
  logic               bready_reg;

  logic [BEATS_W-1:0] calc_beats;
  logic               data_ready;
  logic               w_hs;
  logic               err_next;
  logic [LEN_W-1:0]   remaining_next;

  dma_burst_calc #(
    .DATA_W    (DATA_W),
    .LEN_W     (LEN_W),
    .MAX_BURST (MAX_BURST)
  ) u_burst_calc (
    .addr_lo   (addr_reg[11:0]),
    .remaining (remaining_reg),
    .beats     (calc_beats)
  );

  assign cmd_ready  = cmd_ready_reg;
  assign done       = done_reg;
  assign err        = err_reg;
  assign awaddr     = awaddr_reg;
  assign awlen      = awlen_reg;
  assign awsize     = 3'(SIZE);
  assign awburst    = AXI_BURST_INCR;
  assign awvalid    = awvalid_reg;
  assign wdata      = fifo_dout;
  assign wstrb      = '1;
  assign wlast      = wlast_reg;
  // An empty FIFO can never coincide with W given the pre-check, but drop valid anyway.
  assign wvalid     = wvalid_reg & ~fifo_empty;
  assign bready     = bready_reg;
  assign fifo_rd_en = w_hs;

  // Handshake and bookkeeping terms used by the FSM.
  always_comb begin
    data_ready     = CMP_W'(fifo_ocup_cnt) >= CMP_W'(beats_reg);
    w_hs           = wvalid & wready;
    err_next       = err_sticky_reg | (bresp != AXI_RESP_OKAY);
    remaining_next = remaining_reg - LEN_W'(beats_reg);
  end

  // Command sequencing FSM; every AXI/command output is registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      addr_reg       <= '0;
      remaining_reg  <= '0;
      beats_reg      <= '0;
      beat_cnt_reg   <= '0;
      err_sticky_reg <= 1'b0;
      cmd_ready_reg  <= 1'b0;
      done_reg       <= 1'b0;
      err_reg        <= 1'b0;
      awaddr_reg     <= '0;
      awlen_reg      <= '0;
      awvalid_reg    <= 1'b0;
      wvalid_reg     <= 1'b0;
      wlast_reg      <= 1'b0;
      bready_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      err_reg  <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          cmd_ready_reg <= 1'b1;
          if (cmd_valid && cmd_ready_reg) begin
            cmd_ready_reg  <= 1'b0;
            addr_reg       <= cmd_addr;
            remaining_reg  <= cmd_beats;
            err_sticky_reg <= 1'b0;
            if (cmd_beats == '0) begin
              done_reg  <= 1'b1;
              state_reg <= ST_DONE;
            end else begin
              state_reg <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          beats_reg  <= calc_beats;
          awaddr_reg <= addr_reg;
          awlen_reg  <= 8'(calc_beats - BEATS_W'(1));
          state_reg  <= ST_WAIT_DATA;
        end
        ST_WAIT_DATA: begin
          if (data_ready) begin
            awvalid_reg <= 1'b1;
            state_reg   <= ST_AW;
          end
        end
        ST_AW: begin
          if (awready) begin
            awvalid_reg  <= 1'b0;
            wvalid_reg   <= 1'b1;
            beat_cnt_reg <= '0;
            wlast_reg    <= (beats_reg == BEATS_W'(1));
            state_reg    <= ST_W;
          end
        end
        ST_W: begin
          if (w_hs) begin
            if (wlast_reg) begin
              wvalid_reg <= 1'b0;
              wlast_reg  <= 1'b0;
              bready_reg <= 1'b1;
              state_reg  <= ST_B;
            end else begin
              beat_cnt_reg <= beat_cnt_reg + BEATS_W'(1);
              wlast_reg    <= ((beat_cnt_reg + BEATS_W'(2)) == beats_reg);
            end
          end
        end
        ST_B: begin
          if (bvalid) begin
            bready_reg     <= 1'b0;
            err_sticky_reg <= err_next;
            remaining_reg  <= remaining_next;
            addr_reg       <= addr_reg + (ADDR_W'(beats_reg) << SIZE);
            // An error abandons the rest of the command; leftover FIFO data is the controller's problem.
            if (remaining_next == '0 || err_next) begin
              done_reg  <= 1'b1;
              err_reg   <= err_next;
              state_reg <= ST_DONE;
            end else begin
              state_reg <= ST_CALC;
            end
          end
        end
        ST_DONE: begin
          err_sticky_reg <= 1'b0;
          cmd_ready_reg  <= 1'b1;
          state_reg      <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule
